mc_main_controller: RTL and testbench

- Multicycle MIPS main control FSM; sits directly upstream of alu_controller.
- Sequences instruction execution from the opcode field instruction[31:26].
- Drives alu_op, which tells alu_controller to decode the funct field, plus all datapath mux, memory and register-file enables.
- Supports variable-latency memory through a ready handshake.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_ctrl_decode.sv | 67 ++++++
 rtl/mc_main_controller.sv | 100 ++++++++++
 tb/tb_mc_main_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS main controller: opcodes, state
// encodings, datapath select codes and the decoded control bundle.
package mc_pkg;

    localparam int MC_STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [MC_STATE_W-1:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd13
    } mc_state_e;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic ALU_OP_ADD   = 1'b0;
    localparam logic ALU_OP_FUNCT = 1'b1;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic [1:0] pc_source;
    } mc_ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: current state plus the memory/comparator
// handshakes to the full set of datapath control signals.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  mc_state_e state_i,
    input  logic      mem_ready,
    input  logic      regs_equal,
    output mc_ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready;
                ctrl_o.pc_write  = mem_ready;
            end
            // Precompute the branch target into ALUOut while the opcode is decoded.
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALU_OP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.pc_source = PC_SRC_ALUOUT;
                ctrl_o.pc_write  = regs_equal;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_source = PC_SRC_JUMP;
                ctrl_o.pc_write  = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle MIPS main control FSM: state register, opcode-driven sequencing
// with memory wait states, and the sticky illegal-opcode flag.
module mc_main_controller
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               regs_equal,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);

    mc_state_e state_q, state_d;
    logic      illegal_op_q, illegal_op_d;
    mc_ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_IDLE;
        endcase
    end

    // Raised on the same edge that enters TRAP; only reset clears it.
    always_comb begin
        illegal_op_d = illegal_op_q | (state_d == S_TRAP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i    (state_q),
        .mem_ready  (mem_ready),
        .regs_equal (regs_equal),
        .ctrl_o     (ctrl)
    );

    assign pc_write   = ctrl.pc_write;
    assign ir_write   = ctrl.ir_write;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_dst    = ctrl.reg_dst;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_source  = ctrl.pc_source;
    assign illegal_op = illegal_op_q;
    assign state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_main_controller.sv
// Self-checking bench for mc_main_controller: directed scenarios plus random
// instruction streams checked against a per-instruction cycle-sequence model.
module tb_mc_main_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       regs_equal;
    logic       mem_ready;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, alu_op, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    mc_main_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .regs_equal (regs_equal),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] obs_vec();
        return {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
    endfunction

    // Expected control outputs per state, taken directly from the state table.
    function automatic logic [14:0] exp_vec(int st, bit rdy, bit eq);
        logic pcw, irw, iord, mr, mw, m2r, rd, rw, sa, aop, ill;
        logic [1:0] sb, ps;
        {pcw, irw, iord, mr, mw, m2r, rd, rw, sa, aop, ill} = '0;
        sb = 2'b00;
        ps = 2'b00;
        case (st)
            1:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mr = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; iord = 1; end
            7:  begin sa = 1; aop = 1; end
            8:  begin rw = 1; rd = 1; end
            9:  begin sa = 1; ps = 2'b01; pcw = eq; end
            10: begin sa = 1; sb = 2'b10; end
            11: rw = 1;
            12: begin ps = 2'b10; pcw = 1; end
            13: ill = 1;
            default: ;
        endcase
        return {pcw, irw, iord, mr, mw, m2r, rd, rw, sa, sb, aop, ps, ill};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs at the falling edge, then check state and outputs.
    task automatic step(int st, bit rdy, bit eq);
        @(negedge clk);
        mem_ready  = rdy;
        regs_equal = eq;
        #1;
        check("state", 32'(state_o), 32'(st));
        check("outputs", 32'(obs_vec()), 32'(exp_vec(st, rdy, eq)));
        check("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
    endtask

    // Build the expected FETCH..last-state sequence for one instruction and run it.
    task automatic run_instr(logic [5:0] op, int wf, int wm, bit beq_eq);
        int st_q[$];
        bit rdy_q[$];
        opcode = op;
        for (int i = 0; i < wf; i++) begin st_q.push_back(1); rdy_q.push_back(0); end
        st_q.push_back(1); rdy_q.push_back(1);
        st_q.push_back(2); rdy_q.push_back(1'($urandom));
        case (op)
            6'b000000: begin
                st_q.push_back(7); rdy_q.push_back(1'($urandom));
                st_q.push_back(8); rdy_q.push_back(1'($urandom));
            end
            6'b100011: begin
                st_q.push_back(3); rdy_q.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin st_q.push_back(4); rdy_q.push_back(0); end
                st_q.push_back(4); rdy_q.push_back(1);
                st_q.push_back(5); rdy_q.push_back(1'($urandom));
            end
            6'b101011: begin
                st_q.push_back(3); rdy_q.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin st_q.push_back(6); rdy_q.push_back(0); end
                st_q.push_back(6); rdy_q.push_back(1);
            end
            6'b000100: begin st_q.push_back(9); rdy_q.push_back(1'($urandom)); end
            6'b001000: begin
                st_q.push_back(10); rdy_q.push_back(1'($urandom));
                st_q.push_back(11); rdy_q.push_back(1'($urandom));
            end
            default: begin st_q.push_back(12); rdy_q.push_back(1'($urandom)); end
        endcase
        foreach (st_q[i]) begin
            bit eq;
            eq = (st_q[i] == 9) ? beq_eq : 1'($urandom);
            step(st_q[i], rdy_q[i], eq);
        end
    endtask

    initial begin
        logic [5:0] ops [6];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

        rst = 1'b1; opcode = 6'b0; regs_equal = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_outputs", 32'(obs_vec()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_state", 32'(state_o), 32'd0);
        check("idle_outputs", 32'(obs_vec()), 32'd0);

        // Directed: R-type, LW with 2+2 waits, BEQ both ways, SW with waits, J, ADDI.
        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b100011, 2, 2, 0);
        run_instr(6'b000100, 0, 0, 1);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b101011, 1, 3, 0);
        run_instr(6'b000010, 0, 0, 0);
        run_instr(6'b001000, 0, 0, 0);

        // Asynchronous reset while waiting in MEM_READ.
        opcode = 6'b100011;
        step(1, 1, 0);
        step(2, 0, 0);
        step(3, 0, 0);
        step(4, 0, 0);
        rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_outputs", 32'(obs_vec()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 0);
        check("post_rst_mem_read", 32'(mem_read), 32'd1);
        opcode = 6'b000010;
        step(2, 0, 0);
        step(12, 0, 0);

        // Random instruction stream with random wait states.
        for (int n = 0; n < 40; n++) begin
            run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2),
                      $urandom_range(0, 2), 1'($urandom));
        end

        // Illegal opcode: trap, sticky flag, no enables, cleared only by reset.
        opcode = 6'b111111;
        step(1, 1, 0);
        step(2, 1, 0);
        for (int i = 0; i < 21; i++) step(13, 1'($urandom), 1'($urandom));
        rst = 1'b1;
        #1;
        check("trap_rst_illegal", 32'(illegal_op), 32'd0);
        check("trap_rst_state", 32'(state_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        opcode = 6'b110000 | 6'($urandom_range(1, 15));
        step(1, 1, 0);
        step(2, 0, 0);
        step(13, 0, 0);
        rst = 1'b1;
        #1;
        check("final_rst_illegal", 32'(illegal_op), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
